// File: rtl/srlzr_ctrl_if.sv
// Word handshake between the transmit word source and the frame sequencer.
// The source drives s_data/s_valid and the sequencer answers with s_ready.
interface srlzr_ctrl_if #(
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/srlzr_ctrl.sv
// PISO frame sequencer: start bit, MSB-first data, optional even parity, stop bit(s).
// Define SRLZR_PARITY_EN to insert the parity bit after the data bits.
module srlzr_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int CLK_DIV    = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    srlzr_ctrl_if.slave           s_if,
    output logic [DATA_WIDTH-1:0] piso_x,
    output logic                  piso_load,
    output logic                  piso_shift,
    input  logic                  piso_z,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_next;
    logic [BIT_W-1:0] r_bit;
    logic [BIT_W-1:0] w_bit_next;
    logic             r_tx;
    logic             w_tx_next;
    logic             r_data_sel;
    logic             w_data_sel_next;

    logic w_accept;
    logic w_div_last;
    logic w_data_last;
    logic w_stop_last;

    assign w_accept    = s_if.s_valid && (r_state == ST_IDLE);
    assign w_div_last  = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_data_last = (r_bit == BIT_W'(DATA_WIDTH - 1));
    assign w_stop_last = (r_bit == BIT_W'(STOP_BITS - 1));

`ifdef SRLZR_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^s_if.s_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_tx       <= 1'b1;
            r_data_sel <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_div      <= w_div_next;
            r_bit      <= w_bit_next;
            r_tx       <= w_tx_next;
            r_data_sel <= w_data_sel_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_div_next      = (r_state == ST_IDLE || w_div_last) ? '0 : r_div + DIV_W'(1);
        w_bit_next      = r_bit;
        w_tx_next       = r_tx;
        w_data_sel_next = r_data_sel;
        case (r_state)
            ST_IDLE: begin
                w_bit_next = '0;
                w_tx_next  = 1'b1;
                if (w_accept) begin
                    w_state_next = ST_START;
                    w_tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (w_div_last) begin
                    w_state_next    = ST_DATA;
                    w_bit_next      = '0;
                    w_data_sel_next = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_div_last) begin
                    if (w_data_last) begin
                        w_bit_next      = '0;
                        w_data_sel_next = 1'b0;
`ifdef SRLZR_PARITY_EN
                        w_state_next    = ST_PARITY;
                        w_tx_next       = r_parity;
`else
                        w_state_next    = ST_STOP;
                        w_tx_next       = 1'b1;
`endif
                    end else begin
                        w_bit_next = r_bit + BIT_W'(1);
                    end
                end
            end
`ifdef SRLZR_PARITY_EN
            ST_PARITY: begin
                if (w_div_last) begin
                    w_state_next = ST_STOP;
                    w_bit_next   = '0;
                    w_tx_next    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_div_last) begin
                    if (w_stop_last) begin
                        w_state_next = ST_IDLE;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next = r_bit + BIT_W'(1);
                    end
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_bit_next      = '0;
                w_tx_next       = 1'b1;
                w_data_sel_next = 1'b0;
            end
        endcase
    end

    // During DATA the line follows the PISO flop directly, so each new bit appears on the
    // same edge the PISO shifts; r_data_sel is a flop, keeping the select glitch-free.
    always_comb begin
        s_if.s_ready = (r_state == ST_IDLE);
        piso_load    = w_accept;
        piso_x       = s_if.s_data;
        piso_shift   = (r_state == ST_DATA) && w_div_last && !w_data_last;
        tx           = r_data_sel ? piso_z : r_tx;
        busy         = (r_state != ST_IDLE);
        frame_done   = (r_state == ST_STOP) && w_div_last && w_stop_last;
    end

endmodule

// File: tb/tb_srlzr_ctrl.sv
// Scoreboard bench for srlzr_ctrl: two instances (CLK_DIV=4/STOP=1 and CLK_DIV=1/STOP=2),
// each with a behavioural PISO; every cycle's outputs are checked against queued expectations.
module tb_srlzr_ctrl;

    localparam int DW = 4;
`ifdef SRLZR_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic tx;
        logic busy;
        logic ready;
        logic load;
        logic shift;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    srlzr_ctrl_if #(.DATA_WIDTH(DW)) a_if ();
    srlzr_ctrl_if #(.DATA_WIDTH(DW)) b_if ();

    logic [DW-1:0] a_px, b_px;
    logic          a_ld, a_sh, a_z, a_tx, a_busy, a_done;
    logic          b_ld, b_sh, b_z, b_tx, b_busy, b_done;
    logic [DW-1:0] a_piso = '0;
    logic [DW-1:0] b_piso = '0;

    srlzr_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(4), .STOP_BITS(1)) u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (a_if),
        .piso_x     (a_px),
        .piso_load  (a_ld),
        .piso_shift (a_sh),
        .piso_z     (a_z),
        .tx         (a_tx),
        .busy       (a_busy),
        .frame_done (a_done)
    );

    srlzr_ctrl #(.DATA_WIDTH(DW), .CLK_DIV(1), .STOP_BITS(2)) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (b_if),
        .piso_x     (b_px),
        .piso_load  (b_ld),
        .piso_shift (b_sh),
        .piso_z     (b_z),
        .tx         (b_tx),
        .busy       (b_busy),
        .frame_done (b_done)
    );

    // Behavioural PISO shift registers, MSB out first
    always @(posedge clk) begin
        if (a_ld) a_piso <= a_px;
        else if (a_sh) a_piso <= {a_piso[DW-2:0], 1'b0};
        if (b_ld) b_piso <= b_px;
        else if (b_sh) b_piso <= {b_piso[DW-2:0], 1'b0};
    end
    assign a_z = a_piso[DW-1];
    assign b_z = b_piso[DW-1];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   rem [2];
    exp_t q_a [$];
    exp_t q_b [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int div_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int stops_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    function automatic int frame_len(input int u);
        return (1 + DW + PAR + stops_of(u)) * div_of(u);
    endfunction

    task automatic push_exp(input int u, input exp_t e);
        if (u == 0) q_a.push_back(e);
        else q_b.push_back(e);
    endtask

    // Expected per-cycle outputs for the cycles following an accept edge
    task automatic push_frame(input int u, input logic [DW-1:0] w);
        int   cdiv = div_of(u);
        int   nb   = 1 + DW + PAR + stops_of(u);
        logic bv;
        exp_t e;
        for (int b = 0; b < nb; b++) begin
            if (b == 0) bv = 1'b0;
            else if (b <= DW) bv = w[DW-b];
            else if (PAR == 1 && b == DW + 1) bv = ^w;
            else bv = 1'b1;
            for (int c = 0; c < cdiv; c++) begin
                e.tx    = bv;
                e.busy  = 1'b1;
                e.ready = 1'b0;
                e.load  = 1'b0;
                e.shift = (b >= 1) && (b <= DW - 1) && (c == cdiv - 1);
                e.done  = (b == nb - 1) && (c == cdiv - 1);
                push_exp(u, e);
            end
        end
    endtask

    task automatic cyc(input int u, input logic v, input logic [DW-1:0] d);
        exp_t e;
        exp_t obs;
        logic have;
        if (rem[u] == 0) begin
            e = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, load: v, shift: 1'b0, done: 1'b0};
            push_exp(u, e);
            if (v) begin
                push_frame(u, d);
                rem[u] = frame_len(u);
            end
        end else begin
            rem[u]--;
        end
        @(negedge clk);
        if (u == 0) begin
            a_if.s_valid = v;
            a_if.s_data  = d;
        end else begin
            b_if.s_valid = v;
            b_if.s_data  = d;
        end
        #1;
        have = (u == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
        if (!have) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            if (u == 0) begin
                e   = q_a.pop_front();
                obs = '{tx: a_tx, busy: a_busy, ready: a_if.s_ready, load: a_ld, shift: a_sh, done: a_done};
            end else begin
                e   = q_b.pop_front();
                obs = '{tx: b_tx, busy: b_busy, ready: b_if.s_ready, load: b_ld, shift: b_sh, done: b_done};
            end
            check_val($sformatf("u%0d.tx", u),    32'(obs.tx),    32'(e.tx));
            check_val($sformatf("u%0d.busy", u),  32'(obs.busy),  32'(e.busy));
            check_val($sformatf("u%0d.ready", u), 32'(obs.ready), 32'(e.ready));
            check_val($sformatf("u%0d.load", u),  32'(obs.load),  32'(e.load));
            check_val($sformatf("u%0d.shift", u), 32'(obs.shift), 32'(e.shift));
            check_val($sformatf("u%0d.done", u),  32'(obs.done),  32'(e.done));
        end
    endtask

    task automatic show_frame(input int u, input string what, input logic [DW-1:0] w);
        $display("txn u%0d %s word=%h frame_len=%0d compared=%0d mismatched=%0d",
                 u, what, w, frame_len(u), n_cmp, n_bad);
    endtask

    initial begin
        logic [DW-1:0] w;
        rem[0] = 0;
        rem[1] = 0;
        rst_n = 1'b0;
        a_if.s_valid = 1'b0;
        a_if.s_data  = '0;
        b_if.s_valid = 1'b0;
        b_if.s_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst.tx",    32'(a_tx),          32'd1);
        check_val("rst.busy",  32'(a_busy),        32'd0);
        check_val("rst.ready", 32'(a_if.s_ready),  32'd1);
        check_val("rst.done",  32'(a_done),        32'd0);
        check_val("rst.shift", 32'(a_sh),          32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle line after reset
        repeat (50) cyc(0, 1'b0, '0);
        $display("txn u0 idle 50 cycles compared=%0d mismatched=%0d", n_cmp, n_bad);

        // single frame, valid dropped after accept
        cyc(0, 1'b1, 4'b1011);
        repeat (frame_len(0) + 3) cyc(0, 1'b0, '0);
        show_frame(0, "single", 4'b1011);

        // back-to-back: valid held high, second word waits for IDLE
        cyc(0, 1'b1, 4'hA);
        repeat (frame_len(0)) cyc(0, 1'b1, 4'h5);
        cyc(0, 1'b1, 4'h5);
        repeat (frame_len(0) + 2) cyc(0, 1'b0, '0);
        show_frame(0, "back2back", 4'h5);

        // asynchronous reset in the middle of data bit 2
        cyc(0, 1'b1, 4'b1011);
        repeat (13) cyc(0, 1'b0, '0);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst.tx",    32'(a_tx),         32'd1);
        check_val("arst.busy",  32'(a_busy),       32'd0);
        check_val("arst.ready", 32'(a_if.s_ready), 32'd1);
        check_val("arst.shift", 32'(a_sh),         32'd0);
        q_a.delete();
        rem[0] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn u0 async reset mid-frame compared=%0d mismatched=%0d", n_cmp, n_bad);
        cyc(0, 1'b1, 4'h6);
        repeat (frame_len(0) + 2) cyc(0, 1'b0, '0);
        show_frame(0, "after_reset", 4'h6);

        // random words with short idle gaps
        for (int k = 0; k < 4; k++) begin
            w = DW'($urandom_range(0, 15));
            cyc(0, 1'b1, w);
            repeat (frame_len(0) + int'($urandom_range(0, 2))) cyc(0, 1'b0, '0);
            show_frame(0, "random", w);
        end

        // CLK_DIV=1, STOP_BITS=2 instance
        cyc(1, 1'b1, 4'b0000);
        repeat (frame_len(1) + 2) cyc(1, 1'b0, '0);
        show_frame(1, "zeros", 4'b0000);
        cyc(1, 1'b1, 4'b1011);
        repeat (frame_len(1) + 1) cyc(1, 1'b0, '0);
        show_frame(1, "single", 4'b1011);
        cyc(1, 1'b1, 4'h9);
        repeat (frame_len(1)) cyc(1, 1'b1, 4'h6);
        cyc(1, 1'b1, 4'h6);
        repeat (frame_len(1) + 2) cyc(1, 1'b0, '0);
        show_frame(1, "back2back", 4'h6);

        if (q_a.size() != 0 || q_b.size() != 0)
            check_val("sb_leftover", 32'(q_a.size() + q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
